// File: rtl/glyph_sprite_pkg.sv
// Shared types for the glyph sprite engine: FSM state encoding and a counter width helper.
package glyph_sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DMA,
    ST_REG_DATA,
    ST_WAIT_POS,
    ST_LINE,
    ST_NEXT,
    ST_DONE
  } glyph_sprite_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glyph_sprite_engine_scale_counter.sv
// Modulo-N counter with enable, synchronous clear (priority) and a wrap pulse on the terminal count.
module scale_counter
  import glyph_sprite_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/glyph_sprite_engine.sv
// Scaled 1bpp sprite line engine: one ROM fetch per source line, pixel output aligned to sx.
// Optional macro GLYPH_SPRITE_HFLIP_EN adds an hflip input that mirrors each fetched line.
module glyph_sprite_engine
  import glyph_sprite_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned SCALE_X = 1,
  parameter int unsigned SCALE_Y = 1,
  parameter int unsigned LSB     = 1,
  parameter int unsigned CORDW   = 16,
  parameter int unsigned ADDRW   = $clog2(HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    dma_avail,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sprx,
  input  logic        [WIDTH-1:0] data_in,
`ifdef GLYPH_SPRITE_HFLIP_EN
  input  logic                    hflip,
`endif
  output logic        [ADDRW-1:0] pos,
  output logic                    pix,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned XSW = cnt_width(SCALE_X);
  localparam int unsigned XPW = cnt_width(WIDTH);
  localparam int unsigned YSW = cnt_width(SCALE_Y);

  glyph_sprite_state_t state, next_state;

  logic [WIDTH-1:0]        line_r;
  logic                    flip_r;
  logic [XSW-1:0]          xs_cnt;
  logic [XPW-1:0]          xp_cnt;
  logic [YSW-1:0]          y_cnt;
  logic                    xs_wrap, xp_wrap, y_wrap;
  logic                    in_line;
  logic                    rev;
  logic [XPW-1:0]          bit_idx;
  logic signed [CORDW-1:0] sprx_m1;
  logic                    unused_xs;

  assign in_line   = (state == ST_LINE);
  assign sprx_m1   = sprx - CORDW'(1);
  assign unused_xs = ^xs_cnt;

  // X counters are held clear outside LINE, which is equivalent to clearing them on
  // the WAIT_POS match since LINE is only entered from there.
  scale_counter #(.N(SCALE_X)) u_xscale (
    .clk   (clk),
    .rst   (rst),
    .en    (in_line),
    .clr   (!in_line),
    .count (xs_cnt),
    .wrap  (xs_wrap)
  );

  scale_counter #(.N(WIDTH)) u_xpix (
    .clk   (clk),
    .rst   (rst),
    .en    (xs_wrap),
    .clr   (!in_line),
    .count (xp_cnt),
    .wrap  (xp_wrap)
  );

  scale_counter #(.N(SCALE_Y)) u_yscale (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_NEXT),
    .clr   (start),
    .count (y_cnt),
    .wrap  (y_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     next_state = ST_IDLE;
      ST_WAIT_DMA: if (dma_avail) next_state = ST_REG_DATA;
      ST_REG_DATA: next_state = ST_WAIT_POS;
      ST_WAIT_POS: if (sx == sprx_m1) next_state = ST_LINE;
      ST_LINE:     if (xp_wrap) next_state = ST_NEXT;
      ST_NEXT: begin
        if (y_cnt != YSW'(SCALE_Y - 1))       next_state = ST_WAIT_DMA;
        else if (pos == ADDRW'(HEIGHT - 1))   next_state = ST_DONE;
        else                                  next_state = ST_WAIT_DMA;
      end
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
    if (start) next_state = ST_WAIT_DMA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (start || state == ST_DONE) begin
      pos <= '0;
    end else if (state == ST_NEXT && y_wrap && pos != ADDRW'(HEIGHT - 1)) begin
      pos <= pos + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r <= '0;
    end else if (state == ST_REG_DATA) begin
      line_r <= data_in;
    end
  end

`ifdef GLYPH_SPRITE_HFLIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_r <= 1'b0;
    end else if (state == ST_REG_DATA) begin
      flip_r <= hflip;
    end
  end
`else
  assign flip_r = 1'b0;
`endif

  assign rev     = (LSB != 0) ^ flip_r;
  assign bit_idx = rev ? xp_cnt : XPW'(WIDTH - 1) - xp_cnt;

  always_comb begin
    pix     = 1'b0;
    drawing = 1'b0;
    done    = 1'b0;
    case (state)
      ST_LINE: begin
        drawing = 1'b1;
        pix     = line_r[bit_idx];
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_glyph_sprite_engine.sv
// Self-checking bench: three engine configurations driven by shared scanline sweeps,
// compared cycle by cycle against a scanline-level reference model.
module tb_glyph_sprite_engine;

  localparam int LINE_LEN = 300;
  localparam int DMA_X    = 10;
  localparam int IDLE_DMA = 150;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               dma_avail;
  logic signed [15:0] sx;
  logic signed [15:0] sprx;
  logic [7:0]         data [3];
  logic [2:0]         pos  [3];
  logic               pix  [3];
  logic               drawing [3];
  logic               done [3];

  // Model configuration per instance: 0 = 8x scaled MSB-first, 1 = LSB-first, 2 = MSB-first.
  int   scx [3] = '{8, 1, 1};
  int   scy [3] = '{8, 1, 1};
  bit   lsb [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] rom [3][8];

  int sl;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  glyph_sprite_engine #(.WIDTH(8), .HEIGHT(8), .SCALE_X(8), .SCALE_Y(8), .LSB(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data[0]),
`ifdef GLYPH_SPRITE_HFLIP_EN
    .hflip(1'b0),
`endif
    .pos(pos[0]), .pix(pix[0]), .drawing(drawing[0]), .done(done[0]));

  glyph_sprite_engine #(.WIDTH(8), .HEIGHT(8), .SCALE_X(1), .SCALE_Y(1), .LSB(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data[1]),
`ifdef GLYPH_SPRITE_HFLIP_EN
    .hflip(1'b0),
`endif
    .pos(pos[1]), .pix(pix[1]), .drawing(drawing[1]), .done(done[1]));

  glyph_sprite_engine #(.WIDTH(8), .HEIGHT(8), .SCALE_X(1), .SCALE_Y(1), .LSB(0)) u_c (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data[2]),
`ifdef GLYPH_SPRITE_HFLIP_EN
    .hflip(1'b0),
`endif
    .pos(pos[2]), .pix(pix[2]), .drawing(drawing[2]), .done(done[2]));

  function automatic bit line_valid(int i, int ln);
    return (ln >= 0) && (ln < 8 * scy[i]);
  endfunction

  function automatic bit exp_draw(int i, int ln, int x, int left);
    int off;
    off = x - left;
    return line_valid(i, ln) && off >= 0 && off < 8 * scx[i];
  endfunction

  function automatic bit exp_pix(int i, int ln, int x, int left);
    int k;
    logic [7:0] d;
    if (!exp_draw(i, ln, x, left)) return 1'b0;
    k = (x - left) / scx[i];
    d = rom[i][ln / scy[i]];
    return lsb[i] ? d[k] : d[7 - k];
  endfunction

  function automatic bit exp_done(int i, int ln, int x, int left);
    return (ln == 8 * scy[i] - 1) && (x == left + 8 * scx[i] + 1);
  endfunction

  function automatic int exp_pos(int i, int ln);
    return line_valid(i, ln) ? ln / scy[i] : 0;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s inst=%0d sx=%0d line=%0d observed=%0h expected=%0h", tag, i, sx, sl, obs, exp);
    end
  endtask

  // One scanline sweep. start pulses at sx=0 when do_start; restart_at/rst_at (-1 = none)
  // inject a mid-line start or an asynchronous reset.
  task automatic run_line(input bit do_start, input int restart_at, input int rst_at);
    int left;
    int ln;
    left = int'(sprx);
    if (do_start) sl = 0;
    for (int x = 0; x < LINE_LEN; x++) begin
      @(posedge clk);
      #1;
      sx        = 16'(x);
      start     = (do_start && x == 0) || (x == restart_at);
      dma_avail = (x == DMA_X) || (sl < 0 && x == IDLE_DMA);
      for (int i = 0; i < 3; i++)
        data[i] = (x == DMA_X + 1 && line_valid(i, sl)) ? rom[i][sl / scy[i]] : 8'($urandom);
      if (rst_at >= 0 && x == rst_at + 2) rst = 1'b0;
      if (x == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("rst_pix", i, 32'(pix[i]), 32'd0);
          chk("rst_drawing", i, 32'(drawing[i]), 32'd0);
          chk("rst_done", i, 32'(done[i]), 32'd0);
        end
      end
      @(negedge clk);
      ln = ((restart_at >= 0 && x > restart_at) || (rst_at >= 0 && x >= rst_at)) ? -1 : sl;
      for (int i = 0; i < 3; i++) begin
        chk("pix", i, 32'(pix[i]), 32'(exp_pix(i, ln, x, left)));
        chk("done", i, 32'(done[i]), 32'(exp_done(i, ln, x, left)));
        if (i == 0) chk("drawing", i, 32'(drawing[i]), 32'(exp_draw(i, ln, x, left)));
        if (x == DMA_X) chk("pos", i, 32'(pos[i]), 32'(exp_pos(i, ln)));
        if (restart_at >= 0 && x == restart_at + 1) chk("restart_pos", i, 32'(pos[i]), 32'd0);
      end
    end
    if (rst_at >= 0)          sl = -1;
    else if (restart_at >= 0) sl = 0;
    else if (sl >= 0)         sl++;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dma_avail = 1'b0;
    sx        = '0;
    sprx      = 16'sd204;
    sl        = -1;
    for (int i = 0; i < 3; i++) data[i] = '0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_pix", i, 32'(pix[i]), 32'd0);
      chk("reset_drawing", i, 32'(drawing[i]), 32'd0);
      chk("reset_done", i, 32'(done[i]), 32'd0);
      chk("reset_pos", i, 32'(pos[i]), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // No start: DMA pulses and sweeps must leave everything dark.
    run_line(1'b0, -1, -1);
    run_line(1'b0, -1, -1);

    // Directed frame: 0x81 on the scaled engine, single set bit on the unscaled ones.
    for (int l = 0; l < 8; l++) begin
      rom[0][l] = 8'h81;
      rom[1][l] = 8'h01;
      rom[2][l] = 8'h01;
    end
    run_line(1'b1, -1, -1);
    for (int l = 1; l < 65; l++) run_line(1'b0, -1, -1);

    // Randomized glyphs and position.
    for (int i = 0; i < 3; i++)
      for (int l = 0; l < 8; l++) rom[i][l] = 8'($urandom);
    sprx = 16'($urandom_range(20, 220));
    run_line(1'b1, -1, -1);
    for (int l = 1; l < 65; l++) run_line(1'b0, -1, -1);

    // Mid-line restart while the scaled engine is on source line 1.
    sprx = 16'sd100;
    run_line(1'b1, -1, -1);
    for (int l = 1; l < 10; l++) run_line(1'b0, -1, -1);
    run_line(1'b0, 103, -1);
    run_line(1'b0, -1, -1);
    run_line(1'b0, -1, -1);

    // Asynchronous reset mid-line, then DMA pulses with no start.
    for (int l = 0; l < 8; l++) rom[0][l] = 8'hFF;
    run_line(1'b1, -1, -1);
    run_line(1'b0, -1, 105);
    for (int l = 0; l < 3; l++) run_line(1'b0, -1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/glyph_sprite_engine.md
Name: glyph_sprite_engine

Overview:
- Draws one scaled 1-bit-per-pixel sprite (for example a font glyph) over consecutive scanlines.
- Once per source line, fetches that line from a shared synchronous ROM during a single-cycle DMA slot. The slot sits in horizontal blanking and is granted by the parent.
- Outputs a per-pixel "on" bit aligned to the current screen x coordinate.
- One instance per on-screen character; the parent ORs all `pix` outputs and muxes the ROM address.

Parameters:
- WIDTH, 8, sprite width in pixels; also the `data_in` width.
- HEIGHT, 8, sprite height in source lines.
- SCALE_X, 1, horizontal magnification; each source pixel repeats SCALE_X times.
- SCALE_Y, 1, vertical magnification; each source line repeats on SCALE_Y scanlines.
- LSB, 1, bit order: 1 means bit 0 is the leftmost pixel; 0 means bit WIDTH-1 is the leftmost pixel.
- CORDW, 16, signed screen coordinate width.
- ADDRW, $clog2(HEIGHT), width of the line index `pos`.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse at the start of the first scanline of the sprite.
- dma_avail, input, 1, this instance's ROM slot; ROM address = glyph base + `pos` in this cycle.
- sx, input, CORDW signed, current horizontal screen position.
- sprx, input, CORDW signed, sprite left edge.
- data_in, input, WIDTH, ROM data; valid the cycle after `dma_avail` (1-cycle ROM latency).
- pos, output, ADDRW, current source line index, presented to the parent's ROM address mux.
- pix, output, 1, sprite pixel on at the current `sx`.
- drawing, output, 1, high while the sprite line is being output.
- done, output, 1, one-cycle pulse after the last scanline.

Behaviour:
- States: IDLE, WAIT_DMA, REG_DATA, WAIT_POS, LINE, NEXT, DONE.
- Reset (async): state=IDLE; pos=0; y scale count=0; x pixel count=0; x scale count=0; line register=0; pix=0, drawing=0, done=0.
- `start` in any state: pos=0, y count=0, state=WAIT_DMA. `start` has priority over every other transition, including mid-line restart.
- WAIT_DMA: wait for `dma_avail`; then go to REG_DATA. `pos` is stable during the slot.
- REG_DATA: latch `data_in` into the line register; go to WAIT_POS.
- WAIT_POS: when sx == sprx-1, clear x counters and go to LINE. Equality compare only, signed.
- LINE: `pix` = line register bit at (LSB ? xcnt : WIDTH-1-xcnt), combinational from registered state.
  - Valid in the cycle where sx == sprx + k, for k = 0..WIDTH*SCALE_X-1.
  - x scale count wraps at SCALE_X-1, then xcnt increments.
  - After the final pixel (xcnt == WIDTH-1 and scale count == SCALE_X-1), go to NEXT.
- NEXT (one cycle):
  - If y count < SCALE_Y-1: y count++ and go to WAIT_DMA; the same `pos` is refetched.
  - Otherwise y count=0. If pos == HEIGHT-1, go to DONE; else pos++ and go to WAIT_DMA.
- DONE: `done`=1 for one cycle, then IDLE. In IDLE, `pos` holds 0 after DONE.
- `pix`=0 and `drawing`=0 in every state except LINE; `drawing`=1 exactly in LINE.
- Total coverage: HEIGHT*SCALE_Y scanlines of WIDTH*SCALE_X pixels.
- `dma_avail` outside WAIT_DMA is ignored.
- If `sx` never equals sprx-1 on a line, the engine waits in WAIT_POS into the next line; the parent guarantees the DMA slot precedes sprx-1.

Optional Feature:
- Macro: GLYPH_SPRITE_HFLIP_EN.
- Defined: adds input port `hflip` (1 bit), sampled in REG_DATA. When 1, the effective bit order is inverted (LSB XOR hflip), mirroring the line.
- Undefined: no `hflip` port; bit order is fixed by LSB.

Decomposition:
- Package glyph_sprite_pkg holds the state enum typedef glyph_sprite_state_t.
- Sub-module scale_counter: modulo-N counter with enable, clear and wrap pulse. Instantiated for the x scale, y scale and x pixel counters.

Test Plan:
- WIDTH=8, HEIGHT=8, SCALE_X=SCALE_Y=8, LSB=0, sprx=204, `data_in`=8'h81 on all lines:
  - `pix`=1 for sx 204..211 and 260..267.
  - `pix`=0 at sx 203, 212..259 and 268.
  - `drawing`=1 for sx 204..267.
- Same setup, 64 scanlines with one DMA per line: `pos` sequence is 0 (×8 lines), 1 (×8), … 7 (×8). `done` pulses once after line 64.
- LSB=1, SCALE=1, `data_in`=8'h01: `pix`=1 only at sx==sprx. With LSB=0, `pix`=1 only at sx==sprx+7.
- Assert `start` while in LINE: `pix` drops next cycle, `pos`=0, state returns to WAIT_DMA. A fresh DMA then draws line 0 again.
- Assert `rst` asynchronously mid-LINE (not on a clock edge): `pix`, `drawing` and `done` go to 0 immediately. Further `dma_avail` pulses are ignored until `start`.
- No `start`: `dma_avail` pulses and `sx` sweeps leave `pix`=0 and `done`=0 throughout.
